// File: rtl/lsu_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_if : core-side request/response channel of the load/store unit. Rev 1.0
// ---------------------------------------------------------------------------
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu : RISC-V load/store unit driving the byte-lane mem port. Rev 1.0
// ---------------------------------------------------------------------------
module lsu #(
  parameter int ADDR_WIDTH       = 12,
  parameter int MEM_SIZE_BYTES   = 4096,
  parameter int DATA_WIDTH_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_if.slave                  core,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [0:3]            mem_wenableL,
  output logic [0:3][7:0]       mem_data_w,
  input  logic [0:3][7:0]       mem_data_r
);

  if (DATA_WIDTH_BYTES != 4) begin : g_width_check
    $error("lsu supports only DATA_WIDTH_BYTES = 4");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [0:3]            mem_wenableL_q, mem_wenableL_d;
  logic [0:3][7:0]       mem_data_w_q, mem_data_w_d;

  logic                  req_err;
  logic [0:3]            store_wen;
  logic [0:3][7:0]       store_data;
  logic [31:0]           rd_word, rd_shifted, load_data;

  // Request classification: illegal funct3, misalignment, or beyond mem.
  always_comb begin
    logic legal_f3, misaligned;
    if (core.req_we)
      legal_f3 = !core.req_funct3[2] && (core.req_funct3[1:0] != 2'd3);
    else
      legal_f3 = (core.req_funct3[1:0] != 2'd3) && !(core.req_funct3[2] && core.req_funct3[1]);
    misaligned = ((core.req_funct3[1:0] == 2'd1) && core.req_addr[0]) ||
                 ((core.req_funct3[1:0] == 2'd2) && (core.req_addr[1:0] != 2'd0));
    req_err = !legal_f3 || misaligned || (core.req_addr >= 32'(MEM_SIZE_BYTES));
  end

  always_comb begin
    store_wen  = '1;
    store_data = '0;
    for (int k = 0; k < 4; k++) begin
      case (core.req_funct3[1:0])
        2'd0: begin
          store_wen[k]  = (k[1:0] != core.req_addr[1:0]);
          store_data[k] = core.req_wdata[7:0];
        end
        2'd1: begin
          store_wen[k]  = (k[1] != core.req_addr[1]);
          store_data[k] = k[0] ? core.req_wdata[15:8] : core.req_wdata[7:0];
        end
        default: begin
          store_wen[k]  = 1'b0;
          store_data[k] = core.req_wdata[8*k +: 8];
        end
      endcase
    end
  end

  always_comb begin
    rd_word    = {mem_data_r[3], mem_data_r[2], mem_data_r[1], mem_data_r[0]};
    rd_shifted = rd_word >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'd0:    load_data = {{24{~funct3_q[2] & rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_data = {{16{~funct3_q[2] & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    resp_valid_d   = resp_valid_q;
    resp_err_d     = resp_err_q;
    resp_rdata_d   = resp_rdata_q;
    mem_addr_d     = mem_addr_q;
    mem_wenableL_d = '1;
    mem_data_w_d   = '0;
    case (state_q)
      IDLE: begin
        if (core.req_valid && req_ready_q) begin
          we_d     = core.req_we;
          funct3_d = core.req_funct3;
          off_d    = core.req_addr[1:0];
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = {core.req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (core.req_we) begin
              mem_wenableL_d = store_wen;
              mem_data_w_d   = store_data;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
      end
      RESP: begin
        if (core.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // Async reset lifts the write enables immediately so an aborted store never commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b0;
      we_q           <= 1'b0;
      funct3_q       <= '0;
      off_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      mem_addr_q     <= '0;
      mem_wenableL_q <= '1;
      mem_data_w_q   <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      we_q           <= we_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_wenableL_q <= mem_wenableL_d;
      mem_data_w_q   <= mem_data_w_d;
    end
  end

  assign core.req_ready  = req_ready_q;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wenableL    = mem_wenableL_q;
  assign mem_data_w      = mem_data_w_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lsu : directed + randomized bench for lsu against a byte-array model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if bus();
  logic [11:0]     mem_addr;
  logic [0:3]      mem_wenableL;
  logic [0:3][7:0] mem_data_w;
  logic [0:3][7:0] mem_data_r;

  lsu #(.ADDR_WIDTH(12), .MEM_SIZE_BYTES(4096), .DATA_WIDTH_BYTES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (bus),
    .mem_addr     (mem_addr),
    .mem_wenableL (mem_wenableL),
    .mem_data_w   (mem_data_w),
    .mem_data_r   (mem_data_r)
  );

  // Simple synchronous byte-lane memory standing in for mem.
  logic [7:0] mem_arr [0:4095] = '{default: 8'h00};
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!mem_wenableL[k]) mem_arr[32'(mem_addr) + k] <= mem_data_w[k];
      mem_data_r[k] <= mem_arr[32'(mem_addr) + k];
    end
  end

  logic [7:0] ref_mem [0:4095];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural outcome of one request on a byte-addressed memory.
  function automatic void ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                                   output int lat, output logic [0:3] wen, output logic [0:3][7:0] dw);
    int size;
    logic legal;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((addr % size) != 0) || (addr >= 32'd4096);
    rdata = '0;
    wen   = '1;
    dw    = '0;
    lat   = 1;
    if (err) return;
    for (int k = 0; k < 4; k++) dw[k] = wdata[8*(k % size) +: 8];
    if (we) begin
      lat = 2;
      for (int i = 0; i < size; i++) begin
        ref_mem[addr + i] = wdata[8*i +: 8];
        wen[(addr + i) % 4] = 1'b0;
      end
    end else begin
      lat = 3;
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + i];
      if (f3 < 3'd4 && v[8*size-1])
        for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rdata = v;
    end
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall, input string tag,
                         output logic [31:0] rdata_o, output logic [0:3] wen_o);
    logic exp_err;
    logic [31:0] exp_rdata;
    int exp_lat, lat, nacc, stray;
    logic [0:3] exp_wen;
    logic [0:3][7:0] exp_dw, seen_dw;
    logic [11:0] addr_before, seen_addr;
    logic [31:0] held;
    ref_exec(we, f3, addr, wdata, exp_err, exp_rdata, exp_lat, exp_wen, exp_dw);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.resp_ready = (stall == 0);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    addr_before = mem_addr;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; nacc = 0; stray = 0;
    wen_o = '1; seen_dw = '0; seen_addr = '0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (mem_wenableL != 4'b1111) begin
        nacc++; wen_o = mem_wenableL; seen_dw = mem_data_w; seen_addr = mem_addr;
      end else if (mem_data_w != '0) stray++;
      if (bus.resp_valid) lat = k;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " resp_err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, " resp_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, " write cycles"}, 32'(nacc), (we && !exp_err) ? 32'd1 : 32'd0);
    check({tag, " idle data_w"}, 32'(stray), 32'd0);
    if (we && !exp_err) begin
      check({tag, " wenableL"}, 32'(wen_o), 32'(exp_wen));
      check({tag, " data_w"}, seen_dw, exp_dw);
      check({tag, " mem_addr"}, 32'(seen_addr), addr & 32'h0000_0FFC);
    end
    if (exp_err) check({tag, " mem_addr held"}, 32'(mem_addr), 32'(addr_before));
    rdata_o = bus.resp_rdata;
    held = bus.resp_rdata;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, " stall valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, " stall rdata"}, bus.resp_rdata, held);
      check({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " resp cleared"}, {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
    check({tag, " rdata cleared"}, bus.resp_rdata, 32'd0);
    check({tag, " back to idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [0:3] wn;
    logic e;
    logic [31:0] r;
    int l;
    logic [0:3] w;
    logic [0:3][7:0] d;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h5555_5555; bus.resp_ready = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset req_ready", 32'(bus.req_ready), 32'd0);
      check("reset wenableL", 32'(mem_wenableL), 32'hF);
      check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset req_ready", 32'(bus.req_ready), 32'd1);
    check("post-reset mem_addr", 32'(mem_addr), 32'd0);
    check("post-reset data_w", mem_data_w, 32'd0);

    run_req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 0, "SW 010", rd, wn);
    check("SW 010 wen value", 32'(wn), 32'h0);
    run_req(1'b0, 3'd2, 32'h010, 32'h0, 0, "LW 010", rd, wn);
    check("LW 010 value", rd, 32'hDEADBEEF);
    run_req(1'b1, 3'd0, 32'h013, 32'h80, 0, "SB 013", rd, wn);
    check("SB 013 wen value", 32'(wn), 32'hE);
    run_req(1'b0, 3'd0, 32'h013, 32'h0, 0, "LB 013", rd, wn);
    check("LB 013 value", rd, 32'hFFFFFF80);
    run_req(1'b0, 3'd4, 32'h013, 32'h0, 0, "LBU 013", rd, wn);
    check("LBU 013 value", rd, 32'h00000080);
    run_req(1'b0, 3'd2, 32'h010, 32'h0, 0, "LW 010b", rd, wn);
    check("LW 010b value", rd, 32'h80ADBEEF);
    run_req(1'b1, 3'd1, 32'h012, 32'h1234, 0, "SH 012", rd, wn);
    check("SH 012 wen value", 32'(wn), 32'hC);
    run_req(1'b0, 3'd1, 32'h012, 32'h0, 0, "LH 012", rd, wn);
    check("LH 012 value", rd, 32'h00001234);
    run_req(1'b0, 3'd2, 32'h010, 32'h0, 0, "LW 010c", rd, wn);
    check("LW 010c value", rd, 32'h1234BEEF);

    run_req(1'b0, 3'd2, 32'h011, 32'h0, 0, "ERR LW 011", rd, wn);
    run_req(1'b1, 3'd1, 32'h001, 32'hFFFF, 0, "ERR SH 001", rd, wn);
    run_req(1'b1, 3'd4, 32'h010, 32'hFFFF, 0, "ERR S f3=4", rd, wn);
    run_req(1'b0, 3'd2, 32'h1000, 32'h0, 0, "ERR LW 1000", rd, wn);

    run_req(1'b0, 3'd2, 32'h010, 32'h0, 5, "LW stall", rd, wn);
    check("LW stall value", rd, 32'h1234BEEF);

    // Abort a store in its write cycle; the memory word must survive.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h010; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort access wen", 32'(mem_wenableL), 32'h0);
    rst = 1'b1;
    #1;
    check("abort async wen", 32'(mem_wenableL), 32'hF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    check("abort no resp", 32'(bus.resp_valid), 32'd0);
    run_req(1'b0, 3'd2, 32'h010, 32'h0, 0, "LW after abort", rd, wn);
    check("LW after abort value", rd, 32'h1234BEEF);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = 32'hFF8 + $urandom_range(0, 15);
        1:       a = $urandom;
        default: a = $urandom_range(0, 63);
      endcase
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
              $urandom_range(0, 2), $sformatf("rand%0d", n), rd, wn);
    end

    // Sweep the model's view of the test region against the DUT word by word.
    for (int wa = 0; wa < 64; wa += 4) begin
      ref_exec(1'b0, 3'd2, 32'(wa), 32'h0, e, r, l, w, d);
      run_req(1'b0, 3'd2, 32'(wa), 32'h0, 0, $sformatf("sweep%0d", wa), rd, wn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
